// File: rtl/ball_ctrl.sv
// ball_ctrl: per-frame ball motion engine (serve delay, step, collision resolve, goal detect).
// Latency: an accepted frame tick commits the new ball/velocity/pulses 3 cycles later; busy_o covers the 2 cycles in between.
// Backpressure: none; ticks arriving while busy or paused are dropped, never queued.
// Ports: clk_i/rst_ni clock and async active-low reset; frame_tick_i, pause_i control;
//        player_i/enemy_i paddle rectangles; ball_o ball rectangle; busy_o and one-cycle event pulses.

package ball_pkg;
  typedef struct packed {
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [11:0] right;
    logic [11:0] bottom;
  } sprite_t;
endpackage

module ball_ctrl
  import ball_pkg::*;
#(
  parameter int SCREEN_H_RES  = 640,
  parameter int SCREEN_V_RES  = 480,
  parameter int SCREEN_BORDER = 10,
  parameter int BALL_SIDE     = 10,
  parameter int SPEED_W       = 5,
  parameter int SERVE_DELAY   = 60
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    frame_tick_i,
  input  logic    pause_i,
  input  sprite_t player_i,
  input  sprite_t enemy_i,
  output sprite_t ball_o,
  output logic    busy_o,
  output logic    paddle_hit_o,
  output logic    wall_hit_o,
  output logic    score_player_o,
  output logic    score_enemy_o
);

  localparam int CW    = 12;
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  typedef logic signed [CW-1:0]      coord_t;
  typedef logic signed [SPEED_W-1:0] speed_t;

  localparam coord_t SIDE      = coord_t'(BALL_SIDE);
  localparam coord_t HALF_BALL = coord_t'(BALL_SIDE / 2);
  localparam coord_t CX0       = coord_t'((SCREEN_H_RES - BALL_SIDE) / 2);
  localparam coord_t CY0       = coord_t'((SCREEN_V_RES - BALL_SIDE) / 2);
  localparam coord_t TOP       = coord_t'(SCREEN_BORDER);
  localparam coord_t BOT       = coord_t'(SCREEN_V_RES - SCREEN_BORDER);
  localparam coord_t HRES      = coord_t'(SCREEN_H_RES);
  localparam coord_t ZERO      = coord_t'(0);
  localparam coord_t PAD_MID   = coord_t'(25);  // half of a 50 px paddle
  localparam coord_t SLOW_WIN  = coord_t'(8);   // |off| window that returns a shallow bounce

  localparam speed_t VX_R    = speed_t'(4);
  localparam speed_t VX_L    = speed_t'(-4);
  localparam speed_t VY_SLOW = speed_t'(1);
  localparam speed_t VY_FAST = speed_t'(5);

  typedef enum logic [1:0] {S_SERVE, S_MOVE, S_STEP, S_RESOLVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  coord_t           x_q, x_d, y_q, y_d;
  coord_t           cx_q, cx_d, cy_q, cy_d;
  speed_t           vx_q, vx_d, vy_q, vy_d;
  logic             paddle_hit_q, paddle_hit_d, wall_hit_q, wall_hit_d;
  logic             score_player_q, score_player_d, score_enemy_q, score_enemy_d;

  logic   accept;
  logic   hit_e, hit_p, vy_neg;
  coord_t pad_y, off;
  speed_t vy_mag, vy_pad, vy_res;

  function automatic logic overlap(input sprite_t p, input coord_t x, input coord_t y);
    return (x < coord_t'(p.right)) && ((x + SIDE) > coord_t'(p.x_pos)) &&
           (y < coord_t'(p.bottom)) && ((y + SIDE) > coord_t'(p.y_pos));
  endfunction

  function automatic coord_t sext(input speed_t v);
    return coord_t'({{(CW-SPEED_W){v[SPEED_W-1]}}, v});
  endfunction

  function automatic speed_t vabs(input speed_t v);
    return v[SPEED_W-1] ? -v : v;
  endfunction

  assign accept = frame_tick_i && !pause_i;

  // Paddle contact and vertical shaping; enemy wins if both could match.
  always_comb begin
    hit_e  = vx_q[SPEED_W-1] && overlap(enemy_i, cx_q, cy_q);
    hit_p  = !hit_e && !vx_q[SPEED_W-1] && (vx_q != '0) && overlap(player_i, cx_q, cy_q);
    pad_y  = hit_e ? coord_t'(enemy_i.y_pos) : coord_t'(player_i.y_pos);
    off    = (cy_q + HALF_BALL) - (pad_y + PAD_MID);
    // A dead-centre hit keeps the current vertical direction.
    vy_neg = (off == ZERO) ? vy_q[SPEED_W-1] : off[CW-1];
    vy_mag = ((off <= SLOW_WIN) && (off >= -SLOW_WIN)) ? VY_SLOW : VY_FAST;
    vy_pad = vy_neg ? -vy_mag : vy_mag;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    x_d            = x_q;
    y_d            = y_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    vx_d           = vx_q;
    vy_d           = vy_q;
    vy_res         = vy_q;
    paddle_hit_d   = 1'b0;
    wall_hit_d     = 1'b0;
    score_player_d = 1'b0;
    score_enemy_d  = 1'b0;
    case (state_q)
      S_SERVE: begin
        if (accept) begin
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            cnt_d   = '0;
            state_d = S_MOVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MOVE: begin
        if (accept) state_d = S_STEP;
      end
      S_STEP: begin
        if (!pause_i) begin
          cx_d    = x_q + sext(vx_q);
          cy_d    = y_q + sext(vy_q);
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (!pause_i) begin
          x_d     = cx_q;
          y_d     = cy_q;
          state_d = S_MOVE;
          if (hit_e) begin
            x_d          = coord_t'(enemy_i.right);
            vx_d         = VX_R;
            vy_res       = vy_pad;
            paddle_hit_d = 1'b1;
          end else if (hit_p) begin
            x_d          = coord_t'(player_i.x_pos) - SIDE;
            vx_d         = VX_L;
            vy_res       = vy_pad;
            paddle_hit_d = 1'b1;
          end else if (cx_q <= ZERO) begin
            score_player_d = 1'b1;
          end else if ((cx_q + SIDE) >= HRES) begin
            score_enemy_d = 1'b1;
          end

          if (score_player_d || score_enemy_d) begin
            // Re-serve toward the side that just conceded.
            x_d     = CX0;
            y_d     = CY0;
            vx_d    = score_player_d ? VX_L : VX_R;
            vy_d    = VY_SLOW;
            cnt_d   = '0;
            state_d = S_SERVE;
          end else begin
            // Border clamp runs after paddle shaping so a corner hit applies both.
            vy_d = vy_res;
            if (cy_q < TOP) begin
              y_d        = TOP;
              vy_d       = vabs(vy_res);
              wall_hit_d = 1'b1;
            end else if ((cy_q + SIDE) > BOT) begin
              y_d        = BOT - SIDE;
              vy_d       = -vabs(vy_res);
              wall_hit_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_SERVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_SERVE;
      cnt_q          <= '0;
      x_q            <= CX0;
      y_q            <= CY0;
      cx_q           <= CX0;
      cy_q           <= CY0;
      vx_q           <= VX_R;
      vy_q           <= VY_SLOW;
      paddle_hit_q   <= 1'b0;
      wall_hit_q     <= 1'b0;
      score_player_q <= 1'b0;
      score_enemy_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      vx_q           <= vx_d;
      vy_q           <= vy_d;
      paddle_hit_q   <= paddle_hit_d;
      wall_hit_q     <= wall_hit_d;
      score_player_q <= score_player_d;
      score_enemy_q  <= score_enemy_d;
    end
  end

  assign ball_o         = '{x_pos: x_q, y_pos: y_q, right: x_q + SIDE, bottom: y_q + SIDE};
  assign busy_o         = (state_q == S_STEP) || (state_q == S_RESOLVE);
  assign paddle_hit_o   = paddle_hit_q;
  assign wall_hit_o     = wall_hit_q;
  assign score_player_o = score_player_q;
  assign score_enemy_o  = score_enemy_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: directed bench for ball_ctrl playing one scripted rally.
// Expected positions are hand-computed along the ball path (x += vx, y += vy per move tick).
// Paddles are 10x50 rectangles placed so each event lands on a known tick.

module tb_ball_ctrl;
  import ball_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    frame_tick = 1'b0;
  logic    pause = 1'b0;
  sprite_t player, enemy, ball;
  logic    busy, ph, wh, sp, se;

  int n_chk = 0;
  int n_bad = 0;
  int cnt_ph, cnt_wh, cnt_sp, cnt_se, stray;
  logic b1, b2, b3, l_ph, l_wh, l_sp, l_se;
  int x_t2;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .frame_tick_i  (frame_tick),
    .pause_i       (pause),
    .player_i      (player),
    .enemy_i       (enemy),
    .ball_o        (ball),
    .busy_o        (busy),
    .paddle_hit_o  (ph),
    .wall_hit_o    (wh),
    .score_player_o(sp),
    .score_enemy_o (se)
  );

  function automatic sprite_t mk(input int x, input int y);
    sprite_t s;
    int r, b;
    r = x + 10;
    b = y + 50;
    s.x_pos  = x[11:0];
    s.y_pos  = y[11:0];
    s.right  = r[11:0];
    s.bottom = b[11:0];
    return s;
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, ".x"},      int'(ball.x_pos),  x);
    check({tag, ".y"},      int'(ball.y_pos),  y);
    check({tag, ".right"},  int'(ball.right),  x + 10);
    check({tag, ".bottom"}, int'(ball.bottom), y + 10);
  endtask

  function automatic int pulse_sum();
    return int'(ph) + int'(wh) + int'(sp) + int'(se);
  endfunction

  task automatic clear_counts();
    cnt_ph = 0; cnt_wh = 0; cnt_sp = 0; cnt_se = 0;
  endtask

  task automatic check_pulses(input string tag, input logic p, input logic w, input logic s_p, input logic s_e);
    check({tag, ".paddle_hit"},   int'(l_ph), int'(p));
    check({tag, ".wall_hit"},     int'(l_wh), int'(w));
    check({tag, ".score_player"}, int'(l_sp), int'(s_p));
    check({tag, ".score_enemy"},  int'(l_se), int'(s_e));
  endtask

  task automatic serve_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    stray += pulse_sum();
    @(negedge clk);
    stray += pulse_sum();
  endtask

  // One accepted move tick; samples busy at T+1..T+3 and pulses at T+3.
  task automatic move_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    b1 = busy; stray += pulse_sum();
    @(negedge clk);
    b2 = busy; x_t2 = int'(ball.x_pos); stray += pulse_sum();
    @(negedge clk);
    b3 = busy;
    l_ph = ph; l_wh = wh; l_sp = sp; l_se = se;
    cnt_ph += int'(ph); cnt_wh += int'(wh); cnt_sp += int'(sp); cnt_se += int'(se);
    @(negedge clk);
    stray += pulse_sum();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    stray = 0;
    clear_counts();
    player = mk(610, 287);
    enemy  = mk(30, 600);

    // Reset state
    repeat (3) @(negedge clk);
    check_ball("rst", 315, 235);
    check("rst.busy", int'(busy), 0);
    check("rst.pulses", pulse_sum(), 0);
    rst_n = 1'b1;

    // Serve: ball parked through tick 60, first move on tick 61
    repeat (59) serve_tick();
    check_ball("serve59", 315, 235);
    serve_tick();
    check_ball("serve60", 315, 235);
    move_tick();
    check("mv1.busy_t1", int'(b1), 1);
    check("mv1.busy_t2", int'(b2), 1);
    check("mv1.busy_t3", int'(b3), 0);
    check("mv1.x_at_t2", x_t2, 315);
    check_ball("mv1", 319, 236);

    // Paused tick is ignored
    pause = 1'b1;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check("pause.busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    pause = 1'b0;
    check_ball("pause", 319, 236);

    // Tick held into T+1 is dropped: exactly one advance
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk); frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_ball("drop", 323, 237);

    // Rightward flight into the player paddle centre
    clear_counts();
    repeat (69) move_tick();
    check_ball("k71", 599, 306);
    check("k71.pulses", cnt_ph + cnt_wh + cnt_sp + cnt_se, 0);
    move_tick();
    check_ball("player_hit", 600, 307);
    check_pulses("player_hit", 1'b1, 1'b0, 1'b0, 1'b0);

    // Leftward flight into enemy paddle, low contact -> steep upward
    enemy = mk(30, 448);
    move_tick();
    check_ball("m1", 596, 308);
    clear_counts();
    repeat (139) move_tick();
    check_ball("m140", 40, 447);
    check("m140.pulses", cnt_ph + cnt_wh + cnt_sp + cnt_se, 0);
    move_tick();
    check_ball("enemy_hit", 40, 448);
    check_pulses("enemy_hit", 1'b1, 1'b0, 1'b0, 1'b0);

    // Rising rightward into a paddle touching the top border
    player = mk(400, 0);
    enemy  = mk(30, 600);
    move_tick();
    check_ball("n1", 44, 443);
    repeat (86) move_tick();
    check_ball("n87", 388, 13);
    move_tick();
    check_ball("combo", 390, 10);
    check_pulses("combo", 1'b1, 1'b1, 1'b0, 1'b0);

    // Falling leftward: bottom wall bounce, then left goal
    player = mk(610, 600);
    move_tick();
    check_ball("j1", 386, 15);
    repeat (89) move_tick();
    check_ball("j90", 30, 460);
    move_tick();
    check_ball("bottom_wall", 26, 460);
    check_pulses("bottom_wall", 1'b0, 1'b1, 1'b0, 1'b0);
    move_tick();
    check_ball("j92", 22, 455);
    repeat (5) move_tick();
    check_ball("j97", 2, 430);
    move_tick();
    check_ball("left_goal", 315, 235);
    check_pulses("left_goal", 1'b0, 1'b0, 1'b1, 1'b0);

    // Re-serve goes left after a player score
    repeat (60) serve_tick();
    check_ball("lserve.hold", 315, 235);
    move_tick();
    check_ball("lserve", 311, 236);

    // Reset in the middle of an update
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check("arst.busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_ball("arst", 315, 235);
    check("arst.busy", int'(busy), 0);
    check("arst.pulses", pulse_sum(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s = 0;
    repeat (4) begin
      @(negedge clk);
      s += pulse_sum();
    end
    check("arst.after_pulses", s, 0);
    serve_tick();
    check_ball("arst.serve1", 315, 235);
    repeat (59) serve_tick();
    move_tick();
    check_ball("arst.mv1", 319, 236);

    // Right goal with the player paddle out of the way
    clear_counts();
    repeat (77) move_tick();
    check_ball("k78", 627, 313);
    check("k78.pulses", cnt_ph + cnt_wh + cnt_sp + cnt_se, 0);
    move_tick();
    check_ball("right_goal", 315, 235);
    check_pulses("right_goal", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (60) serve_tick();
    move_tick();
    check_ball("rserve", 319, 236);

    check("stray_pulses", stray, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
